// File: rtl/minirv_ifu.sv
// miniRV instruction fetch/decode front end: owns the PC, fetches one word at a time from
// instruction memory, decodes it and holds it for execute until consumed or redirected.
module minirv_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] imm_q, imm_d;
  logic        illegal_q, illegal_d;

  logic [31:0] rsp_inst;
  logic [31:0] imm_dec;
  logic        illegal_dec;
  logic [31:0] redirect_target;

  assign rsp_inst        = imem_rsp_data;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Immediate decode of the word coming back from memory, used only when it is latched.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm_dec     = '0;
    illegal_dec = 1'b0;
    unique case (rsp_inst[6:0])
      OPC_OP_IMM: begin
        if (rsp_inst[14:12] == 3'b001 || rsp_inst[14:12] == 3'b101)
          imm_dec = {27'b0, rsp_inst[24:20]};
        else
          imm_dec = {{20{rsp_inst[31]}}, rsp_inst[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm_dec = {{20{rsp_inst[31]}}, rsp_inst[31:20]};
      OPC_STORE:
        imm_dec = {{20{rsp_inst[31]}}, rsp_inst[31:25], rsp_inst[11:7]};
      OPC_BRANCH:
        imm_dec = {{19{rsp_inst[31]}}, rsp_inst[31], rsp_inst[7], rsp_inst[30:25],
                   rsp_inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_dec = {rsp_inst[31:12], 12'b0};
      OPC_JAL:
        imm_dec = {{11{rsp_inst[31]}}, rsp_inst[31], rsp_inst[19:12], rsp_inst[20],
                   rsp_inst[30:21], 1'b0};
      OPC_OP:
        imm_dec = '0;
      default:
        illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_valid_d = inst_valid_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    imm_d        = imm_q;
    illegal_d    = illegal_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      S_REQ: begin
        if (redirect_valid) begin
          // An accepted request still owes a response, which must be thrown away.
          fetch_pc_d = redirect_target;
          state_d    = imem_req_ready ? S_DRAIN : S_REQ;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          inst_valid_d = 1'b1;
          pc_d         = fetch_pc_q;
          inst_d       = rsp_inst;
          imm_d        = imm_dec;
          illegal_d    = illegal_dec;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          fetch_pc_d   = redirect_target;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          fetch_pc_d   = fetch_pc_q + 32'd4;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) fetch_pc_d = redirect_target;
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    req_valid_d = (state_d == S_REQ);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      imm_q        <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      imm_q        <= imm_d;
      illegal_q    <= illegal_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = inst_valid_q;
  assign pc             = pc_q;
  assign opcode         = inst_q[6:0];
  assign rd             = inst_q[11:7];
  assign funct3         = inst_q[14:12];
  assign rs1            = inst_q[19:15];
  assign rs2            = inst_q[24:20];
  assign funct7         = inst_q[31:25];
  assign imm            = imm_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_minirv_ifu.sv
// Directed bench for minirv_ifu: the bench plays instruction memory and execute by hand and
// compares the decoded outputs against hand-computed values.
module tb_minirv_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  minirv_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .pc             (pc),
    .opcode         (opcode),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct3         (funct3),
    .funct7         (funct7),
    .imm            (imm),
    .illegal        (illegal)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, accept it, return data the next cycle.
  // On return the instruction is expected to be presented.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    int n = 0;
    while (!imem_req_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, " req_addr"}, imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    check({tag, " no_valid_t+1"}, 32'(inst_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    check({tag, " inst_valid_t+2"}, 32'(inst_valid), 32'd1);
    check({tag, " pc"}, pc, exp_addr);
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  logic [31:0] imm_vec_data [5];
  logic [31:0] imm_vec_imm  [5];

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;

    // Reset state
    tick();
    check("rst inst_valid", 32'(inst_valid), 32'd0);
    check("rst req_valid", 32'(imem_req_valid), 32'd0);
    check("rst pc", pc, 32'h8000_0000);
    check("rst imm", imm, 32'h0);
    check("rst opcode", 32'(opcode), 32'h0);
    check("rst illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle->req", 32'(imem_req_valid), 32'd1);

    // addi x1,x0,5
    do_fetch("addi", 32'h8000_0000, 32'h0050_0093);
    check("addi opcode", 32'(opcode), 32'h13);
    check("addi rd", 32'(rd), 32'd1);
    check("addi rs1", 32'(rs1), 32'd0);
    check("addi funct3", 32'(funct3), 32'd0);
    check("addi imm", imm, 32'd5);
    check("addi illegal", 32'(illegal), 32'd0);
    check("hold no req", 32'(imem_req_valid), 32'd0);
    consume();
    check("after consume valid", 32'(inst_valid), 32'd0);
    check("next addr", imem_req_addr, 32'h8000_0004);

    // srai x2,x1,3: funct7 must not leak into the shift amount
    do_fetch("srai", 32'h8000_0004, 32'h4030_D113);
    check("srai funct3", 32'(funct3), 32'd5);
    check("srai funct7", 32'(funct7), 32'h20);
    check("srai rd", 32'(rd), 32'd2);
    check("srai rs1", 32'(rs1), 32'd1);
    check("srai imm", imm, 32'd3);
    consume();

    // addi x1,x0,-1
    do_fetch("addi-1", 32'h8000_0008, 32'hFFF0_0093);
    check("addi-1 imm", imm, 32'hFFFF_FFFF);
    consume();

    // add x3,x1,x2, then held for 5 cycles
    do_fetch("add", 32'h8000_000C, 32'h0020_81B3);
    check("add opcode", 32'(opcode), 32'h33);
    check("add rd", 32'(rd), 32'd3);
    check("add rs1", 32'(rs1), 32'd1);
    check("add rs2", 32'(rs2), 32'd2);
    check("add imm", imm, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall valid", 32'(inst_valid), 32'd1);
      check("stall rd", 32'(rd), 32'd3);
      check("stall rs2", 32'(rs2), 32'd2);
      check("stall pc", pc, 32'h8000_000C);
      check("stall no req", 32'(imem_req_valid), 32'd0);
    end
    consume();

    // Unsupported opcode is still presented, flagged illegal
    do_fetch("illegal", 32'h8000_0010, 32'h0000_007F);
    check("illegal flag", 32'(illegal), 32'd1);
    check("illegal opcode", 32'(opcode), 32'h7F);
    check("illegal imm", imm, 32'h0);
    consume();

    // Remaining immediate formats: lui, beq -4, sw 8, jal -8, lw -16
    imm_vec_data[0] = 32'h1234_50B7; imm_vec_imm[0] = 32'h1234_5000;
    imm_vec_data[1] = 32'hFE00_0EE3; imm_vec_imm[1] = 32'hFFFF_FFFC;
    imm_vec_data[2] = 32'h0020_A423; imm_vec_imm[2] = 32'h0000_0008;
    imm_vec_data[3] = 32'hFF9F_F06F; imm_vec_imm[3] = 32'hFFFF_FFF8;
    imm_vec_data[4] = 32'hFF01_2083; imm_vec_imm[4] = 32'hFFFF_FFF0;
    for (int i = 0; i < 5; i++) begin
      do_fetch("fmt", 32'h8000_0014 + 32'(i * 4), imm_vec_data[i]);
      check("fmt imm", imm, imm_vec_imm[i]);
      check("fmt illegal", 32'(illegal), 32'd0);
      consume();
    end

    // Redirect while waiting; the late response must be discarded
    check("pre-redirect addr", imem_req_addr, 32'h8000_0028);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 2; i++) begin
      check("drain no req", 32'(imem_req_valid), 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("drain no valid", 32'(inst_valid), 32'd0);
    check("drain req", 32'(imem_req_valid), 32'd1);
    check("redirect addr", imem_req_addr, 32'h8000_0100);
    do_fetch("redir", 32'h8000_0100, 32'h0020_81B3);
    check("redir rd", 32'(rd), 32'd3);

    // Redirect while holding drops the held instruction
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    tick();
    redirect_valid = 1'b0;
    check("hold redirect valid", 32'(inst_valid), 32'd0);
    check("hold redirect req", 32'(imem_req_valid), 32'd1);
    check("hold redirect addr", imem_req_addr, 32'h0000_1000);

    // Asynchronous reset while holding
    do_fetch("prerst", 32'h0000_1000, 32'h0050_0093);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 32'(inst_valid), 32'd0);
    check("async rst pc", pc, 32'h8000_0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("post rst req", 32'(imem_req_valid), 32'd1);
    check("post rst addr", imem_req_addr, 32'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
